// File: rtl/sub_exec_responder_pkg.sv
// Shared types for the subcore dispatch responder: FSM state encoding and
// result-buffer address width helper.
package inst_package;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEFAULT_RESULT_DEPTH = 32;

  // Address width for a result buffer of the given depth (never below 1 bit).
  function automatic int result_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int RESULT_ADDR_W = result_addr_w(DEFAULT_RESULT_DEPTH);

endpackage

// File: rtl/sub_exec_responder_result_buf.sv
// sub_result_buf: 1W1R synchronous result RAM with write-first bypass; the top
// word reads back CORE_NUM until it is first written after reset.
module sub_result_buf
  import inst_package::*;
#(
  parameter int DEPTH    = 32,
  parameter int CORE_NUM = 0,
  parameter int ADDR_W   = result_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  logic [31:0] mem [DEPTH];
  logic        top_written;

  // Storage itself is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      top_written <= 1'b0;
      rdata       <= 32'd0;
    end else begin
      if (we && (waddr == TOP_ADDR)) begin
        top_written <= 1'b1;
      end
      if (we && (waddr == raddr)) begin
        rdata <= wdata;
      end else if ((raddr == TOP_ADDR) && !top_written) begin
        rdata <= 32'(CORE_NUM);
      end else begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/sub_exec_responder.sv
// Subcore-side responder: accepts main's exec request, pulses the pipeline start,
// drains after halt and serves result-buffer reads. Option: SUB_EXEC_REQ_QUEUE_EN.
//
// Handshake: exec_requested is a level sampled every cycle and accepted only in
// IDLE; core_start is a one-cycle pulse with core_pc valid alongside it;
// subcore_ended is low from acceptance until the drain completes.
module sub_exec_responder
  import inst_package::*;
#(
  parameter int CORE_NUM     = 0,
  parameter int RESULT_DEPTH = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   exec_requested,
  input  logic [31:0]                            requested_pc,
  output logic                                   subcore_ended,
  input  logic [31:0]                            fetch_addr,
  output logic [31:0]                            fetch_result,
  output logic                                   core_start,
  output logic [31:0]                            core_pc,
  input  logic                                   core_halted,
  input  logic                                   core_busy,
  input  logic                                   res_we,
  input  logic [result_addr_w(RESULT_DEPTH)-1:0] res_addr,
  input  logic [31:0]                            res_wdata,
  output state_t                                 dbg_state
);

  localparam int ADDR_W = result_addr_w(RESULT_DEPTH);
  localparam int CNT_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic             drain_done;
  logic             unused_fetch_hi;

  assign dbg_state       = state;
  assign drain_done      = (state == DRAIN) && (drain_cnt == '0) && !core_busy;
  assign unused_fetch_hi = ^fetch_addr[31:ADDR_W];

`ifdef SUB_EXEC_REQ_QUEUE_EN
  logic        pend_valid;
  logic [31:0] pend_pc;

  // First request arriving while busy wins; the slot empties when it is consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
    end else if (drain_done) begin
      pend_valid <= 1'b0;
    end else if (exec_requested && !pend_valid && (state != IDLE)) begin
      pend_valid <= 1'b1;
      pend_pc    <= requested_pc;
    end
  end
`endif

  // core_pc doubles as the latched start PC and holds after START.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      subcore_ended <= 1'b1;
      core_start    <= 1'b0;
      core_pc       <= 32'd0;
      drain_cnt     <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (exec_requested) begin
            core_pc       <= requested_pc;
            core_start    <= 1'b1;
            subcore_ended <= 1'b0;
            state         <= START;
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          if (core_halted) begin
            drain_cnt <= DRAIN_LOAD;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
          end else if (!core_busy) begin
`ifdef SUB_EXEC_REQ_QUEUE_EN
            if (pend_valid) begin
              core_pc    <= pend_pc;
              core_start <= 1'b1;
              state      <= START;
            end else
`endif
            begin
              subcore_ended <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sub_result_buf #(
    .DEPTH    (RESULT_DEPTH),
    .CORE_NUM (CORE_NUM),
    .ADDR_W   (ADDR_W)
  ) u_result_buf (
    .clk   (clk),
    .rstn  (rstn),
    .we    (res_we),
    .waddr (res_addr),
    .wdata (res_wdata),
    .raddr (fetch_addr[ADDR_W-1:0]),
    .rdata (fetch_result)
  );

endmodule
